// File: rtl/wb_master_arbiter_if.sv
// Pipelined Wishbone bundle used by all three arbiter ports.
// MASTER drives the request side; SLAVE drives the response side.
interface wishbone_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   rdata;
  logic            ack;
  logic            err;
  logic            stall;

  modport MASTER (
    output cyc, stb, we, adr, wdata, sel,
    input  rdata, ack, err, stall
  );

  modport SLAVE (
    input  cyc, stb, we, adr, wdata, sel,
    output rdata, ack, err, stall
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone (pipelined) arbiter, grant locked for the whole cyc.
// Optional bus watchdog: define WB_ARB_WATCHDOG_EN to add the ABORT state and wd timer.
//
// state  | meaning
// IDLE   | no grant, s_if.cyc low
// GRANT0 | m0 owns s_if until it drops cyc
// GRANT1 | m1 owns s_if until it drops cyc
// ABORT  | watchdog fired; wait for the aborted master to drop cyc
module wb_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int OUTST_W        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wishbone_if.SLAVE  m0_if,
  wishbone_if.SLAVE  m1_if,
  wishbone_if.MASTER s_if,
  output logic [1:0] grant_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
`ifdef WB_ARB_WATCHDOG_EN
    , ABORT
`endif
  } state_t;

  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

  state_t          state, state_next;
  logic            last_grant;
  logic [OUTST_W-1:0] outst;
  logic            gnt0, gnt1, full, accepted, resp;
  logic            abort_err0, abort_err1;
  logic            mx_cyc, mx_stb, mx_we;
  logic [AW-1:0]   mx_adr;
  logic [DW-1:0]   mx_wdata;
  logic [DW/8-1:0] mx_sel;

  // Grants are masked by reset so the ports are quiet during the reset cycle itself.
  always_comb begin
    gnt0     = (state == GRANT0) && !rst_i;
    gnt1     = (state == GRANT1) && !rst_i;
    full     = (outst == OUTST_MAX);
    mx_cyc   = 1'b0;
    mx_stb   = 1'b0;
    mx_we    = 1'b0;
    mx_adr   = '0;
    mx_wdata = '0;
    mx_sel   = '0;
    if (gnt0) begin
      mx_cyc   = m0_if.cyc;
      mx_stb   = m0_if.stb;
      mx_we    = m0_if.we;
      mx_adr   = m0_if.adr;
      mx_wdata = m0_if.wdata;
      mx_sel   = m0_if.sel;
    end else if (gnt1) begin
      mx_cyc   = m1_if.cyc;
      mx_stb   = m1_if.stb;
      mx_we    = m1_if.we;
      mx_adr   = m1_if.adr;
      mx_wdata = m1_if.wdata;
      mx_sel   = m1_if.sel;
    end
    accepted = mx_stb && !full && !s_if.stall;
    resp     = (gnt0 || gnt1) && (s_if.ack || s_if.err);
  end

  always_comb begin
    s_if.cyc    = mx_cyc;
    s_if.stb    = mx_stb && !full;
    s_if.we     = mx_we;
    s_if.adr    = mx_adr;
    s_if.wdata  = mx_wdata;
    s_if.sel    = mx_sel;
    m0_if.stall = gnt0 ? (s_if.stall || full) : 1'b1;
    m0_if.ack   = gnt0 && s_if.ack;
    m0_if.err   = (gnt0 && s_if.err) || abort_err0;
    m0_if.rdata = s_if.rdata;
    m1_if.stall = gnt1 ? (s_if.stall || full) : 1'b1;
    m1_if.ack   = gnt1 && s_if.ack;
    m1_if.err   = (gnt1 && s_if.err) || abort_err1;
    m1_if.rdata = s_if.rdata;
    grant_o     = {gnt1, gnt0};
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd;
  logic            wd_hit, abort_m, abort_first;

  assign wd_hit     = (wd == WD_W'(TIMEOUT_CYCLES));
  assign abort_err0 = abort_first && !abort_m && !rst_i;
  assign abort_err1 = abort_first && abort_m && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd          <= '0;
      abort_m     <= 1'b0;
      abort_first <= 1'b0;
    end else begin
      abort_first <= (state_next == ABORT) && (state != ABORT);
      if ((state_next == ABORT) && (state != ABORT))
        abort_m <= (state == GRANT1);
      if ((state_next != state) || resp || (outst == '0) || !(gnt0 || gnt1))
        wd <= '0;
      else if (!wd_hit)
        wd <= wd + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort_err0     = 1'b0;
  assign abort_err1     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_if.cyc && m1_if.cyc)
          state_next = last_grant ? GRANT0 : GRANT1;
        else if (m0_if.cyc)
          state_next = GRANT0;
        else if (m1_if.cyc)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (!m0_if.cyc)
          state_next = m1_if.cyc ? GRANT1 : IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_hit)
          state_next = ABORT;
`endif
      end
      GRANT1: begin
        if (!m1_if.cyc)
          state_next = m0_if.cyc ? GRANT0 : IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_hit)
          state_next = ABORT;
`endif
      end
`ifdef WB_ARB_WATCHDOG_EN
      ABORT: begin
        if (!(abort_m ? m1_if.cyc : m0_if.cyc))
          state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Any state change drops the outstanding count, which also covers abandoned cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      outst      <= '0;
    end else begin
      state <= state_next;
      if ((state_next == GRANT0) && (state != GRANT0))
        last_grant <= 1'b0;
      else if ((state_next == GRANT1) && (state != GRANT1))
        last_grant <= 1'b1;
      if (state_next != state)
        outst <= '0;
      else if (accepted && !resp)
        outst <= outst + 1'b1;
      else if (!accepted && resp && (outst != '0))
        outst <= outst - 1'b1;
    end
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone (pipelined) arbiter sharing one downstream slave port between the instruction-side fetch master and the data-side master. It sits upstream of the main mux, so both CPU paths reach the shared platform peripherals and memory through a single port. Arbitration is round-robin with grant lock for the whole bus cycle (`cyc`). Outstanding transfers are tracked per grant, and a compile-time bus watchdog is available.

## Interface
Parameters:
- `AW`, 32, address width carried by all three ports.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `OUTST_W`, 3, width of the outstanding-transfer counter; at most `2**OUTST_W-1` transfers in flight.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles; used only with `WB_ARB_WATCHDOG_EN`.

Ports (each bus port is a `wishbone_if` carrying `cyc, stb, we, adr[AW], wdata[DW], sel[DW/8], rdata[DW], ack, err, stall`):
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `m0_if`  wishbone_if.SLAVE  —  instruction-side master (fetch).
- `m1_if`  wishbone_if.SLAVE  —  data-side master.
- `s_if`  wishbone_if.MASTER  —  shared downstream slave (main mux).
- `grant_o`  out  2  one-hot current grant; `00` when idle or aborting. For debug and perf counters.

## Operation
- States: IDLE, GRANT0, GRANT1, ABORT (ABORT exists only with the watchdog).
- Request = master's `cyc`.
- IDLE transitions:
  - One request → GRANTx of that master.
  - Both requesting → the master not named in `last_grant`. `last_grant` resets to 1, so m0 wins the first tie.
- GRANTx behaviour:
  - Granted master's `cyc, stb, we, adr, wdata, sel` drive `s_if` combinationally.
  - `s_if` `ack, err, rdata` route to the granted master.
  - `s_if.stall` routes to the granted master, ORed with the counter-full stall (see below).
  - `last_grant` ← x on entry.
- Grant lock:
  - Held while the granted master's `cyc`=1.
  - When `cyc` drops: → GRANTy if the other master is requesting, else IDLE.
  - `s_if.cyc` is therefore 0 for exactly one cycle between grants.
- Non-granted master sees `stall`=1, `ack`=0, `err`=0. Its `rdata` is don't-care.
- Outstanding counter:
  - +1 on an accepted strobe (`s_if.stb & !s_if.stall`); −1 on `s_if.ack|s_if.err`; unchanged when both happen in the same cycle.
  - Cleared on every grant change.
  - At max value, the arbiter forces master stall=1 and `s_if.stb`=0 until a response arrives.
- If the master drops `cyc` with the counter nonzero (abandoned cycle), release anyway and clear the counter. Late responses arriving while IDLE or under a new grant after a one-cycle gap are not the arbiter's concern; the downstream slave must honour a `cyc` drop.

## Timing
- Reset values: state=IDLE, `last_grant`=1, counter=0, watchdog=0, `grant_o`=00.
- Outputs under reset: `s_if.cyc/stb`=0; both masters `stall`=1, `ack`=0, `err`=0.
- Grant latency: `cyc` rising in IDLE → GRANT registered at the next edge. The first `s_if.stb` can appear in the cycle after the request.
- Steady state: zero added latency. Request and response paths are combinational through the arbiter.
- Reset asserted mid-transfer: the next edge returns all state to reset values. `s_if.cyc` is 0 in the cycle after the reset edge.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - Counter `wd` increments each GRANT cycle with outstanding>0 and no ack/err. It clears on any response or grant change.
  - When `wd`==`TIMEOUT_CYCLES`, go to ABORT:
    - The granted master receives `err`=1 for exactly one cycle, the first ABORT cycle.
    - `s_if.cyc`=0 throughout ABORT; slave responses are ignored.
    - Stay in ABORT until the aborted master's `cyc`=0, then go to IDLE.
    - Outstanding counter is cleared on entry.
- Macro undefined: no ABORT state, no `wd` counter; a hung slave hangs the granted master indefinitely.

## Test plan
- Single master: m1 read at `0x2000_0010`, slave acks after 3 cycles with `0xDEADBEEF` → `grant_o`=10 one cycle after `cyc`; m1 gets ack and `rdata`=`0xDEADBEEF`; m0 sees `stall`=1 throughout.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle → m0 granted first. When m0 drops `cyc`, `grant_o`=10 at the next edge with one `s_if.cyc`=0 cycle between. The next tie goes to m0 again because `last_grant`=1.
- Outstanding limit: `OUTST_W`=2, m0 issues 5 back-to-back strobes, slave holds ack → the 4th strobe sees `stall`=1 and `s_if.stb`=0. After one ack, the 4th is accepted. Counter returns to 0 after 5 acks.
- Abandoned cycle: m1 drops `cyc` with 2 outstanding while m0 is requesting → `grant_o`=01 at the next edge; counter reads 0.
- Watchdog (`WB_ARB_WATCHDOG_EN`, `TIMEOUT_CYCLES`=16): slave never acks m0's read → m0 `err` pulses exactly once, 16 cycles after the stall begins. `s_if.cyc`=0; ABORT holds until m0 `cyc`=0, then IDLE.
- Reset mid-burst: `rst_i` pulsed during m1's 2nd of 4 transfers → next cycle `s_if.cyc`=0, `grant_o`=00, both masters `stall`=1. A subsequent tie goes to m0.
